// File: rtl/regfile_if.sv
// Register-file bus: one write channel from write-back and two read channels
// from decode. The master side drives requests, the slave returns read data.
interface regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  re1;
   logic [ADDR_WIDTH-1:0] raddr1;
   logic [DATA_WIDTH-1:0] rdata1;
   logic                  re2;
   logic [ADDR_WIDTH-1:0] raddr2;
   logic [DATA_WIDTH-1:0] rdata2;

   modport master (
      output we, waddr, wdata,
      output re1, raddr1, re2, raddr2,
      input  rdata1, rdata2
   );

   modport slave (
      input  we, waddr, wdata,
      input  re1, raddr1, re2, raddr2,
      output rdata1, rdata2
   );
endinterface

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports with same-cycle
// write-to-read bypass, one synchronous write port, and a hard-wired zero
// register. rst is asynchronous and active-low and also blanks both read ports.
module regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_NUM    = 32
) (
   input  logic      clk,
   input  logic      rst,
   regfile_if.slave  bus
);

   logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
   logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
   logic [DATA_WIDTH-1:0] rdata1_d;
   logic [DATA_WIDTH-1:0] rdata2_d;

   // Next-state of the array: at most one register changes; register 0 stays 0.
   always_comb begin
      regs_d = regs_q;
      if (bus.we && (bus.waddr != '0)) begin
         regs_d[bus.waddr] = bus.wdata;
      end
      regs_d[0] = '0;
   end

   // Storage update; asynchronous clear discards any write in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read port 1: reset, zero register, bypass, stored value, disabled.
   always_comb begin
      rdata1_d = '0;
      if (!rst) begin
         rdata1_d = '0;
      end else if (bus.raddr1 == '0) begin
         rdata1_d = '0;
      end else if (bus.re1 && bus.we && (bus.waddr == bus.raddr1)) begin
         rdata1_d = bus.wdata;
      end else if (bus.re1) begin
         rdata1_d = regs_q[bus.raddr1];
      end
   end

   // Read port 2: same priority as port 1, evaluated independently.
   always_comb begin
      rdata2_d = '0;
      if (!rst) begin
         rdata2_d = '0;
      end else if (bus.raddr2 == '0) begin
         rdata2_d = '0;
      end else if (bus.re2 && bus.we && (bus.waddr == bus.raddr2)) begin
         rdata2_d = bus.wdata;
      end else if (bus.re2) begin
         rdata2_d = regs_q[bus.raddr2];
      end
   end

   assign bus.rdata1 = rdata1_d;
   assign bus.rdata2 = rdata2_d;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, basic write/read, zero register, bypass,
// dual-port independence and a full sweep of all registers.
module tb_regfile;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One write across a single rising edge; inputs change on the falling edge.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      bus.we    = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      $display("write r%0d <= %h", a, d);
   endtask

   task automatic test_reset;
      // Held in reset from time 0: outputs must be 0 even with reads enabled.
      bus.re1 = 1'b1; bus.raddr1 = 5'd5;
      bus.re2 = 1'b1; bus.raddr2 = 5'd5;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0) begin
         n_fail++; $display("FAIL reset_init_p1: got %h expected %h", bus.rdata1, 32'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      do_write(5'd5, 32'hDEADBEEF);
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL reset_pre_p1: got %h expected %h", bus.rdata1, 32'hDEADBEEF);
      end
      // Assert reset mid-cycle with a write pending to r6.
      @(negedge clk);
      bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h66666666;
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0) begin
         n_fail++; $display("FAIL reset_async_p1: got %h expected %h", bus.rdata1, 32'h0);
      end
      n_checks++;
      if (bus.rdata2 !== 32'h0) begin
         n_fail++; $display("FAIL reset_async_p2: got %h expected %h", bus.rdata2, 32'h0);
      end
      @(posedge clk);
      @(negedge clk);
      bus.we = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0) begin
         n_fail++; $display("FAIL reset_cleared_r5: got %h expected %h", bus.rdata1, 32'h0);
      end
      bus.raddr2 = 5'd6;
      #1;
      n_checks++;
      if (bus.rdata2 !== 32'h0) begin
         n_fail++; $display("FAIL reset_discard_r6: got %h expected %h", bus.rdata2, 32'h0);
      end
      $display("reset test done");
   endtask

   task automatic test_basic;
      do_write(5'd3, 32'h0000FFFF);
      bus.re1 = 1'b1; bus.raddr1 = 5'd3;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0000FFFF) begin
         n_fail++; $display("FAIL basic_read_r3: got %h expected %h", bus.rdata1, 32'h0000FFFF);
      end
      bus.re1 = 1'b0;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0) begin
         n_fail++; $display("FAIL basic_re_off: got %h expected %h", bus.rdata1, 32'h0);
      end
      $display("read r3 -> %h (re1=0)", bus.rdata1);
   endtask

   task automatic test_zero_reg;
      @(negedge clk);
      bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'h12345678;
      bus.re1 = 1'b1; bus.raddr1 = 5'd0;
      bus.re2 = 1'b1; bus.raddr2 = 5'd0;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0) begin
         n_fail++; $display("FAIL zero_same_cycle_p1: got %h expected %h", bus.rdata1, 32'h0);
      end
      n_checks++;
      if (bus.rdata2 !== 32'h0) begin
         n_fail++; $display("FAIL zero_same_cycle_p2: got %h expected %h", bus.rdata2, 32'h0);
      end
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0) begin
         n_fail++; $display("FAIL zero_after_p1: got %h expected %h", bus.rdata1, 32'h0);
      end
      n_checks++;
      if (bus.rdata2 !== 32'h0) begin
         n_fail++; $display("FAIL zero_after_p2: got %h expected %h", bus.rdata2, 32'h0);
      end
      $display("write r0 <= 12345678 ignored");
   endtask

   task automatic test_bypass;
      do_write(5'd7, 32'h11111111);
      @(negedge clk);
      bus.re1 = 1'b0;
      bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h22222222;
      bus.re2 = 1'b1; bus.raddr2 = 5'd7;
      #1;
      n_checks++;
      if (bus.rdata2 !== 32'h22222222) begin
         n_fail++; $display("FAIL bypass_p2: got %h expected %h", bus.rdata2, 32'h22222222);
      end
      bus.wdata = 32'h33333333;
      #1;
      n_checks++;
      if (bus.rdata2 !== 32'h33333333) begin
         n_fail++; $display("FAIL bypass_midcycle: got %h expected %h", bus.rdata2, 32'h33333333);
      end
      bus.re2 = 1'b0;
      #1;
      n_checks++;
      if (bus.rdata2 !== 32'h0) begin
         n_fail++; $display("FAIL bypass_re_off: got %h expected %h", bus.rdata2, 32'h0);
      end
      // Drop the write before the edge: storage must still hold the old value.
      bus.we = 1'b0; bus.re2 = 1'b1;
      #1;
      n_checks++;
      if (bus.rdata2 !== 32'h11111111) begin
         n_fail++; $display("FAIL bypass_stored: got %h expected %h", bus.rdata2, 32'h11111111);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.rdata2 !== 32'h11111111) begin
         n_fail++; $display("FAIL bypass_no_write: got %h expected %h", bus.rdata2, 32'h11111111);
      end
      $display("bypass r7 checked");
   endtask

   task automatic test_dual_port;
      do_write(5'd1, 32'hAAAA0000);
      do_write(5'd2, 32'h0000BBBB);
      @(negedge clk);
      bus.re1 = 1'b1; bus.raddr1 = 5'd1;
      bus.re2 = 1'b1; bus.raddr2 = 5'd2;
      bus.we = 1'b1; bus.waddr = 5'd2; bus.wdata = 32'h0000CCCC;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'hAAAA0000) begin
         n_fail++; $display("FAIL dual_p1: got %h expected %h", bus.rdata1, 32'hAAAA0000);
      end
      n_checks++;
      if (bus.rdata2 !== 32'h0000CCCC) begin
         n_fail++; $display("FAIL dual_p2_bypass: got %h expected %h", bus.rdata2, 32'h0000CCCC);
      end
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      bus.raddr1 = 5'd2;
      #1;
      n_checks++;
      if (bus.rdata1 !== 32'h0000CCCC) begin
         n_fail++; $display("FAIL dual_same_addr_p1: got %h expected %h", bus.rdata1, 32'h0000CCCC);
      end
      n_checks++;
      if (bus.rdata2 !== 32'h0000CCCC) begin
         n_fail++; $display("FAIL dual_same_addr_p2: got %h expected %h", bus.rdata2, 32'h0000CCCC);
      end
      $display("dual read r1/r2 -> %h %h", bus.rdata1, bus.rdata2);
   endtask

   task automatic test_sweep;
      logic [DW-1:0] exp1;
      logic [DW-1:0] exp2;
      logic [AW-1:0] a2;
      for (int i = 1; i < 32; i++) begin
         do_write(AW'(i), DW'(i) * 32'h01010101);
      end
      bus.re1 = 1'b1; bus.re2 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         a2 = AW'(31 - i);
         bus.raddr1 = AW'(i);
         bus.raddr2 = a2;
         exp1 = DW'(i) * 32'h01010101;
         exp2 = DW'(a2) * 32'h01010101;
         #1;
         n_checks++;
         if (bus.rdata1 !== exp1) begin
            n_fail++; $display("FAIL sweep_p1 r%0d: got %h expected %h", i, bus.rdata1, exp1);
         end
         n_checks++;
         if (bus.rdata2 !== exp2) begin
            n_fail++; $display("FAIL sweep_p2 r%0d: got %h expected %h", a2, bus.rdata2, exp2);
         end
         $display("read r%0d -> %h, r%0d -> %h", i, bus.rdata1, a2, bus.rdata2);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
      bus.re1 = 1'b0; bus.raddr1 = '0;
      bus.re2 = 1'b0; bus.raddr2 = '0;
      test_reset;
      test_basic;
      test_zero_reg;
      test_bypass;
      test_dual_port;
      test_sweep;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
